// File: rtl/sync_byte_fifo_pkg.sv
// sync_byte_fifo_pkg: widths shared with the bus synchronizer and drop-counter limit
package sync_byte_fifo_pkg;
  localparam int DEF_BUS_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam logic [7:0] DROP_CNT_MAX = 8'hFF;
endpackage

// File: rtl/sync_byte_fifo_if.sv
// sync_byte_fifo_if: push, show-ahead pop and status signals of the byte FIFO
interface sync_byte_fifo_if import sync_byte_fifo_pkg::*; #(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  logic [BUS_WIDTH-1:0] wr_data;
  logic wr_pulse;
  logic [BUS_WIDTH-1:0] rd_data;
  logic rd_valid;
  logic rd_ready;
  logic full;
  logic empty;
  logic [ADDR_WIDTH:0] count;
  logic overflow;
  logic ovf_clr;
  logic [7:0] drop_cnt;
  modport slave (
    input wr_data, wr_pulse, rd_ready, ovf_clr,
    output rd_data, rd_valid, full, empty, count, overflow, drop_cnt
  );
  modport master (
    output wr_data, wr_pulse, rd_ready, ovf_clr,
    input rd_data, rd_valid, full, empty, count, overflow, drop_cnt
  );
endinterface

// File: rtl/sync_byte_fifo_mem.sv
// sync_byte_fifo_mem: DEPTH x BUS_WIDTH storage, sync write, async read, cleared on reset
module sync_byte_fifo_mem #(
  parameter int BUS_WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [BUS_WIDTH-1:0]  i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [BUS_WIDTH-1:0]  o_rdata
);
  logic [BUS_WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    else if (i_we)
      r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sync_byte_fifo.sv
// sync_byte_fifo: show-ahead FIFO behind the bus synchronizer with sticky overflow and drop count
module sync_byte_fifo import sync_byte_fifo_pkg::*; #(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic             i_clk,
  input logic             i_rst_n,
  sync_byte_fifo_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_WIDTH:0] r_count;
  logic r_overflow;
  logic [7:0] r_drop_cnt;
  logic w_full, w_empty, w_pop, w_push, w_drop;
  logic [BUS_WIDTH-1:0] w_rd_data;
  assign w_full = r_count == FULL_CNT;
  assign w_empty = r_count == '0;
  assign w_pop = ~w_empty & bus.rd_ready;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push = bus.wr_pulse & (~w_full | w_pop);
  assign w_drop = bus.wr_pulse & ~w_push;
  sync_byte_fifo_mem #(.BUS_WIDTH(BUS_WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_we(w_push),
    .i_waddr(r_wr_ptr),
    .i_wdata(bus.wr_data),
    .i_raddr(r_rd_ptr),
    .o_rdata(w_rd_data)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push != w_pop) r_count <= w_push ? r_count + 1'b1 : r_count - 1'b1;
    end
  // clear wins over a same-cycle drop, so that drop is never recorded
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (bus.ovf_clr) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      r_drop_cnt <= (r_drop_cnt == DROP_CNT_MAX) ? r_drop_cnt : r_drop_cnt + 1'b1;
    end
  assign bus.rd_data = w_rd_data;
  assign bus.rd_valid = ~w_empty;
  assign bus.full = w_full;
  assign bus.empty = w_empty;
  assign bus.count = r_count;
  assign bus.overflow = r_overflow;
  assign bus.drop_cnt = r_drop_cnt;
endmodule

// File: doc/sync_byte_fifo.md
# sync_byte_fifo

Buffers bytes arriving from the bus synchronizer so they are not lost while the consumer is busy. Sits directly downstream of the data synchronizer in the destination clock domain. Each single-cycle enable pulse pushes the synchronized bus word into a small FIFO. A consumer drains the FIFO through a show-ahead valid/ready handshake. Overflow is reported, never silently ignored.

## Interface
- BUS_WIDTH, 8, width of each stored word; equals the synchronizer bus width.
- DEPTH, 4, number of entries; power of two, at least 2.
- ADDR_WIDTH, $clog2(DEPTH), pointer index width (derived, not overridden).
- CLK  in  1  destination-domain clock; all logic on posedge.
- RST  in  1  asynchronous, active-low reset.
- wr_data  in  BUS_WIDTH  word from the synchronizer's sync_bus.
- wr_pulse  in  1  push request from the synchronizer's enable_pulse; one cycle per word.
- rd_data  out  BUS_WIDTH  head-of-FIFO word; valid while rd_valid=1.
- rd_valid  out  1  FIFO non-empty.
- rd_ready  in  1  consumer accepts rd_data this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; set when a push is dropped.
- ovf_clr  in  1  synchronous clear of overflow and drop_cnt.
- drop_cnt  out  8  saturating count of dropped pushes.

## Operation
- pop = rd_valid & rd_ready. push_ok = wr_pulse & (~full | pop).
- Push: mem[wr_ptr] <= wr_data. wr_ptr increments modulo DEPTH and wraps from DEPTH-1 to 0.
- Pop: rd_ptr increments modulo DEPTH.
- count update:
  - push_ok & ~pop: +1.
  - pop & ~push_ok: -1.
  - Both or neither: unchanged.
- Simultaneous push and pop when full: both accepted. count stays DEPTH. No overflow.
- Simultaneous push and pop when empty: not possible, since pop requires rd_valid.
- Dropped push (wr_pulse & full & ~pop):
  - overflow <= 1.
  - drop_cnt increments and saturates at 8'hFF.
  - FIFO contents, pointers and count are unchanged.
- ovf_clr has priority over a same-cycle drop: overflow <= 0 and drop_cnt <= 0. That cycle's drop is not recorded.
- rd_ready while empty: ignored. No pointer movement, no underflow.
- rd_data = mem[rd_ptr], combinational read. Its value while empty is don't-care, but is deterministic 0 after reset.
- Reset (RST=0, any time, including mid-transfer):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0, drop_cnt=0, all mem entries=0.
  - Resulting outputs: rd_valid=0, empty=1, full=0, rd_data=0.
  - Partially drained contents are discarded.
- Release from reset is synchronous to CLK. Assertion takes effect asynchronously.

## Timing
- Write-to-read latency: a word pushed at posedge N is on rd_data with rd_valid=1 after posedge N, i.e. in cycle N+1. Same-cycle bypass is not allowed.
- Pop at posedge M: the next entry appears on rd_data in cycle M+1.
- full, empty, count and rd_valid are registered-state derived. They change only after a clock edge.
- overflow and drop_cnt update at the edge of the dropped pulse.
- Sustained throughput is one word per cycle with rd_ready held high. The synchronizer rate is far lower.

## Structure
- Shared header/package holds:
  - default BUS_WIDTH and DEPTH, shared with the synchronizer so the widths cannot diverge;
  - the DROP_CNT_MAX constant 8'hFF.
- One natural sub-module, sync_byte_fifo_mem:
  - DEPTH x BUS_WIDTH storage;
  - synchronous write, asynchronous read, async active-low reset.
- The top level holds pointers, count, flags and the drop counter.

## Test plan
- Reset, then push 8'hAB, 8'hCD, 8'hEF (one pulse each, rd_ready=0) -> count=3, rd_valid=1, rd_data=8'hAB; then rd_ready=1 for 3 cycles -> rd_data sequence AB, CD, EF, then empty=1.
- Fill with 8'h01..8'h04, then push 8'h05 with rd_ready=0 -> full=1, overflow=1, drop_cnt=1; draining yields 01..04 only.
- When full, pulse wr_pulse=1 with 8'h55 and rd_ready=1 in the same cycle -> count stays 4, overflow stays 0, 8'h55 is read last; check pointer wrap after 2*DEPTH pushes.
- Assert RST low mid-stream with count=2 -> rd_valid=0, count=0, rd_data=0 immediately; a post-reset push of 8'h9A reads back 8'h9A.
- Do 300 dropped pushes while full -> drop_cnt saturates at 8'hFF; ovf_clr together with a further drop -> overflow=0, drop_cnt=0.
- Hold rd_ready=1 while empty for 5 cycles, then push 8'h3C -> no underflow; count=1 and 8'h3C is popped one cycle after it appears.
